// File: rtl/sram_arb2_ctrl_if.sv
// Requester and SRAM-pin bundle for sram_arb2_ctrl.
// slave = the arbiter/sequencer, master = requesters plus the SRAM macro.
interface sram_arb2_ctrl_if #(
  parameter int DW = 26,
  parameter int AW = 8
);
  logic          R0_REQ, R0_WE, R0_GNT, R0_RVALID;
  logic [AW-1:0] R0_ADDR;
  logic [DW-1:0] R0_WDATA, R0_RDATA;
  logic          R1_REQ, R1_WE, R1_GNT, R1_RVALID;
  logic [AW-1:0] R1_ADDR;
  logic [DW-1:0] R1_WDATA, R1_RDATA;
  logic          INIT_DONE;
  logic          NCE, NWRT;
  logic [AW-3:0] RA;
  logic [1:0]    CA;
  logic [DW-1:0] DIN, DO;

  modport slave (
    input  R0_REQ, R0_WE, R0_ADDR, R0_WDATA,
    input  R1_REQ, R1_WE, R1_ADDR, R1_WDATA,
    input  DO,
    output R0_GNT, R0_RVALID, R0_RDATA,
    output R1_GNT, R1_RVALID, R1_RDATA,
    output INIT_DONE, NCE, NWRT, RA, CA, DIN
  );

  modport master (
    output R0_REQ, R0_WE, R0_ADDR, R0_WDATA,
    output R1_REQ, R1_WE, R1_ADDR, R1_WDATA,
    output DO,
    input  R0_GNT, R0_RVALID, R0_RDATA,
    input  R1_GNT, R1_RVALID, R1_RDATA,
    input  INIT_DONE, NCE, NWRT, RA, CA, DIN
  );
endinterface

// File: rtl/sram_arb2_ctrl.sv
// Two-port round-robin arbiter / sequencer for a single-port register-file SRAM.
// Clears the array after reset, then issues at most one command per cycle.
// Every SRAM pin comes straight from a flop; reads return two cycles after accept.
module sram_arb2_ctrl #(
  parameter int DW             = 26,
  parameter int AW             = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            CLK,
  input  logic            NRST,
  sram_arb2_ctrl_if.slave bus
);
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;
  localparam logic [AW-1:0] CNT_LAST = '1;

  state_e        state_q;
  logic [AW-1:0] cnt_q, addr_q;
  logic          pri_q, nce_q, nwrt_q, init_done_q;
  logic [DW-1:0] din_q;

  logic [1:0]    req, gnt_d;
  logic          acc, win, acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  // read tag pipe: stage 1 = command on the pins, stage 2 = DO valid
  logic [2:1]    vld_pipe_q, port_pipe_q;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  assign req = {bus.R1_REQ, bus.R0_REQ};

  // Round-robin grant; PRI only matters when both ports request
  always_comb begin
    gnt_d = 2'b00;
    if (NRST && state_q == S_RUN) begin
      case (req)
        2'b01:   gnt_d = 2'b01;
        2'b10:   gnt_d = 2'b10;
        2'b11:   gnt_d = pri_q ? 2'b10 : 2'b01;
        default: gnt_d = 2'b00;
      endcase
    end
  end

  assign acc       = |gnt_d;
  assign win       = gnt_d[1];
  assign acc_we    = win ? bus.R1_WE    : bus.R0_WE;
  assign acc_addr  = win ? bus.R1_ADDR  : bus.R0_ADDR;
  assign acc_wdata = win ? bus.R1_WDATA : bus.R0_WDATA;

  // Sequencer FSM: clear sweep, then registered command issue and priority flip
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q     <= CLEAR_ON_RESET ? S_INIT : S_RUN;
      cnt_q       <= '0;
      pri_q       <= 1'b0;
      nce_q       <= 1'b1;
      nwrt_q      <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == S_INIT) begin
      nce_q  <= 1'b0;
      nwrt_q <= 1'b0;
      addr_q <= cnt_q;
      din_q  <= '0;
      cnt_q  <= cnt_q + AW'(1);
      if (cnt_q == CNT_LAST) begin
        state_q     <= S_RUN;
        init_done_q <= 1'b1;
      end
    end else begin
      init_done_q <= 1'b1;
      if (acc) begin
        nce_q  <= 1'b0;
        nwrt_q <= ~acc_we;
        addr_q <= acc_addr;
        if (acc_we) din_q <= acc_wdata;
        pri_q  <= ~win;
      end else begin
        nce_q  <= 1'b1;
        nwrt_q <= 1'b1;
      end
    end
  end

  // Read return: shift the port tag along with the SRAM access, capture DO at stage 2
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      vld_pipe_q  <= '0;
      port_pipe_q <= '0;
      rvalid_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      vld_pipe_q[1]  <= acc & ~acc_we;
      port_pipe_q[1] <= win;
      vld_pipe_q[2]  <= vld_pipe_q[1];
      port_pipe_q[2] <= port_pipe_q[1];
      rvalid_q[0]    <= vld_pipe_q[2] & ~port_pipe_q[2];
      rvalid_q[1]    <= vld_pipe_q[2] &  port_pipe_q[2];
      if (vld_pipe_q[2] && !port_pipe_q[2]) rdata0_q <= bus.DO;
      if (vld_pipe_q[2] &&  port_pipe_q[2]) rdata1_q <= bus.DO;
    end
  end

  assign bus.R0_GNT    = gnt_d[0];
  assign bus.R1_GNT    = gnt_d[1];
  assign bus.R0_RVALID = rvalid_q[0];
  assign bus.R1_RVALID = rvalid_q[1];
  assign bus.R0_RDATA  = rdata0_q;
  assign bus.R1_RDATA  = rdata1_q;
  assign bus.INIT_DONE = init_done_q;
  assign bus.NCE       = nce_q;
  assign bus.NWRT      = nwrt_q;
  assign bus.RA        = addr_q[AW-1:2];
  assign bus.CA        = addr_q[1:0];
  assign bus.DIN       = din_q;
endmodule

// File: tb/tb_sram_arb2_ctrl.sv
// Bench for sram_arb2_ctrl: behavioural SRAM, abstract memory/ordering model,
// directed sections followed by randomized two-port traffic.
module tb_sram_arb2_ctrl;
  localparam int DW = 26;
  localparam int AW = 8;

  logic clk, nrst, nrst2;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  sram_arb2_ctrl_if #(.DW(DW), .AW(AW)) ifc ();
  sram_arb2_ctrl_if #(.DW(DW), .AW(AW)) ifc2 ();

  sram_arb2_ctrl #(.DW(DW), .AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(clk), .NRST(nrst), .bus(ifc));
  sram_arb2_ctrl #(.DW(DW), .AW(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .CLK(clk), .NRST(nrst2), .bus(ifc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro: samples the pins at the edge, DO updates after that edge
  logic [DW-1:0] sram [256];
  always @(posedge clk)
    if (ifc.NCE === 1'b0) begin
      if (ifc.NWRT === 1'b0) sram[{ifc.RA, ifc.CA}] <= ifc.DIN;
      else                   ifc.DO <= sram[{ifc.RA, ifc.CA}];
    end

  // reference: array contents in acceptance order and expected responses per port
  typedef struct { int due; logic [DW-1:0] d; } rsp_t;
  logic [DW-1:0] mem_ref [256];
  rsp_t q0[$], q1[$];
  int   last_win;
  bit   [1:0] pend;
  bit   we_r [2];
  logic [AW-1:0] ad_r [2];
  logic [DW-1:0] wd_r [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // each port's RVALID/RDATA must match the head of its queue when due, and be idle otherwise
  always @(negedge clk) begin
    bit e0, e1;
    e0 = (q0.size() > 0) && (q0[0].due == cyc);
    e1 = (q1.size() > 0) && (q1[0].due == cyc);
    chk("r0_rvalid", ifc.R0_RVALID, e0);
    chk("r1_rvalid", ifc.R1_RVALID, e1);
    if (e0) begin chk("r0_rdata", ifc.R0_RDATA, q0[0].d); void'(q0.pop_front()); end
    if (e1) begin chk("r1_rdata", ifc.R1_RDATA, q1[0].d); void'(q1.pop_front()); end
  end

  function automatic logic [1:0] exp_gnt();
    if (pend == 2'b11) return (last_win == 1) ? 2'b01 : 2'b10;
    return pend;
  endfunction

  task automatic model_reset();
    foreach (mem_ref[i]) mem_ref[i] = '0;
    q0.delete(); q1.delete();
    last_win = 1;
    pend = 2'b00;
  endtask

  task automatic drive();
    ifc.R0_REQ = pend[0]; ifc.R0_WE = we_r[0]; ifc.R0_ADDR = ad_r[0]; ifc.R0_WDATA = wd_r[0];
    ifc.R1_REQ = pend[1]; ifc.R1_WE = we_r[1]; ifc.R1_ADDR = ad_r[1]; ifc.R1_WDATA = wd_r[1];
  endtask

  task automatic req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; we_r[p] = we; ad_r[p] = a; wd_r[p] = d;
  endtask

  // one clock: present pending requests, check grant, retire the winner into the model
  task automatic step();
    logic [1:0] eg;
    int w;
    rsp_t r;
    drive();
    #1;
    eg = exp_gnt();
    chk("gnt", {ifc.R1_GNT, ifc.R0_GNT}, eg);
    if (eg != 2'b00) begin
      w = eg[1] ? 1 : 0;
      if (we_r[w]) mem_ref[ad_r[w]] = wd_r[w];
      else begin
        r.due = cyc + 3;
        r.d   = mem_ref[ad_r[w]];
        if (w == 0) q0.push_back(r); else q1.push_back(r);
      end
      pend[w]  = 1'b0;
      last_win = w;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pins"}, {ifc.NCE, ifc.NWRT, ifc.RA, ifc.CA, ifc.DIN}, {2'b11, 6'd0, 2'd0, 26'd0});
    chk({tag, "_outs"}, {ifc.R0_RVALID, ifc.R1_RVALID, ifc.INIT_DONE, ifc.R0_GNT, ifc.R1_GNT}, 5'b0);
    chk({tag, "_rd0"}, ifc.R0_RDATA, 26'd0);
    chk({tag, "_rd1"}, ifc.R1_RDATA, 26'd0);
  endtask

  // clear sweep: 256 write-zero cycles at addresses 0..255, no grant until done
  task automatic run_init();
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("init",
          {ifc.R1_GNT, ifc.R0_GNT, ifc.NCE, ifc.NWRT, ifc.RA, ifc.CA, (ifc.DIN == '0), ifc.INIT_DONE},
          {((k == 256) ? exp_gnt() : 2'b00), 2'b00, 8'(k - 1), 1'b1, (k == 256)});
    end
    pend = 2'b00;
    step();
    chk("init_idle", {ifc.NCE, ifc.NWRT, ifc.INIT_DONE}, 3'b111);
  endtask

  initial begin
    int i0, i1, nw;
    nrst = 1'b1; nrst2 = 1'b1;
    for (int p = 0; p < 2; p++) begin we_r[p] = 1'b0; ad_r[p] = '0; wd_r[p] = '0; end
    model_reset();
    ifc2.R0_REQ = 1'b0; ifc2.R0_WE = 1'b0; ifc2.R0_ADDR = '0; ifc2.R0_WDATA = '0;
    ifc2.R1_REQ = 1'b0; ifc2.R1_WE = 1'b0; ifc2.R1_ADDR = '0; ifc2.R1_WDATA = '0;
    ifc2.DO = '0;
    #2 nrst = 1'b0; nrst2 = 1'b0;

    // reset with both requests held high
    req(0, 1'b1, 8'h33, 26'h155_5555);
    req(1, 1'b0, 8'h44, 26'h0);
    drive();
    repeat (3) @(negedge clk);
    #1 check_reset("rst");
    @(negedge clk);
    nrst = 1'b1;
    run_init();

    // cleared location reads zero
    req(0, 1'b0, 8'hA7, '0); step();
    repeat (3) step();

    // single port write then read of the same word
    req(0, 1'b1, 8'h5C, 26'h2AB_CDEF); step();
    req(0, 1'b0, 8'h5C, '0);           step();
    repeat (3) step();

    // preload 0x10..0x15, ending on port 1 so port 0 has priority
    for (int i = 0; i < 6; i++) begin
      req(i % 2, 1'b1, 8'(8'h10 + i), 26'($urandom)); step();
    end
    // contention: both ports read continuously for 6 cycles
    i0 = 0; i1 = 0;
    for (int c = 0; c < 6; c++) begin
      if (!pend[0] && i0 < 3) begin req(0, 1'b0, 8'(8'h10 + 2 * i0), '0); i0++; end
      if (!pend[1] && i1 < 3) begin req(1, 1'b0, 8'(8'h11 + 2 * i1), '0); i1++; end
      step();
    end
    repeat (3) step();

    // hazard: R0 wins once so PRI=1, then R1 write / R0 read to 0x03 together
    req(0, 1'b0, 8'h07, '0); step();
    req(1, 1'b1, 8'h03, 26'h111_1111);
    req(0, 1'b0, 8'h03, '0);
    step(); step();
    // read before write returns old data, following read sees new data
    req(0, 1'b0, 8'h03, '0);           step();
    req(1, 1'b1, 8'h03, 26'h222_2222); step();
    req(0, 1'b0, 8'h03, '0);           step();
    repeat (3) step();

    // randomized traffic, requests held until granted
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 3) != 0)
          req(p, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)),
              26'($urandom));
      step();
    end
    pend = 2'b00;
    repeat (4) step();
    chk("drain", {32'(q0.size()), 32'(q1.size())}, 64'd0);

    // reset one cycle after a read accept: response is dropped, sweep restarts
    req(0, 1'b0, 8'h5C, '0); step();
    step();
    #1 nrst = 1'b0;
    model_reset();
    drive();
    #1 check_reset("mid");
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    run_init();
    req(0, 1'b0, 8'h5C, '0); step();
    repeat (4) step();
    chk("drain2", {32'(q0.size()), 32'(q1.size())}, 64'd0);

    // no-clear variant: grant right after release, never writes on its own
    ifc2.R0_REQ = 1'b1; ifc2.R0_WE = 1'b0; ifc2.R0_ADDR = 8'h40;
    #1 chk("nc_gnt_rst", {ifc2.R1_GNT, ifc2.R0_GNT}, 2'b00);
    @(negedge clk);
    nrst2 = 1'b1;
    #1 chk("nc_gnt", {ifc2.R1_GNT, ifc2.R0_GNT}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk("nc_first", {ifc2.INIT_DONE, ifc2.NCE, ifc2.NWRT}, 3'b101);
    ifc2.R0_REQ = 1'b0;
    nw = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc2.NWRT !== 1'b1) nw++;
    end
    chk("nc_nowrite", nw, 0);
    chk("nc_idle", {ifc2.NCE, ifc2.INIT_DONE}, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_arb2_ctrl.md
# sram_arb2_ctrl

Two-port round-robin arbiter and sequencer for the 256x26 single-port synchronous register-file SRAM (NCE/NWRT/RA/CA/DIN/DO interface). It sits between two internal requesters and the SRAM macro, clears the array after reset, and then accepts up to one read or write per cycle. All SRAM pins are driven from registers, and read data is returned to the requester that issued the read, tagged by port.

## Interface
Parameters:
- DW, 26, data width (SRAM word)
- AW, 8, word address width; RA = addr[AW-1:2], CA = addr[1:0]
- CLEAR_ON_RESET, 1, 1 = zero all 2^AW words after reset before granting

Ports:
- CLK  in  1  clock; all logic on posedge
- NRST  in  1  reset, asynchronous, active-low
- R0_REQ / R1_REQ  in  1  request valid, held until granted
- R0_WE / R1_WE  in  1  1 = write, 0 = read
- R0_ADDR / R1_ADDR  in  AW  word address
- R0_WDATA / R1_WDATA  in  DW  write data
- R0_GNT / R1_GNT  out  1  combinational grant; REQ&GNT at posedge = accepted
- R0_RVALID / R1_RVALID  out  1  one-cycle read-data valid pulse
- R0_RDATA / R1_RDATA  out  DW  read data, held until next RVALID for that port
- INIT_DONE  out  1  high once clearing is complete (sticky until reset)
- NCE  out  1  SRAM chip enable, active-low, registered
- NWRT  out  1  SRAM write enable, active-low, registered
- RA  out  AW-2  SRAM row address, registered
- CA  out  2  SRAM column address, registered
- DIN  out  DW  SRAM write data, registered
- DO  in  DW  SRAM read data

## Operation
- FSM: INIT -> RUN. Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
- INIT:
  - 8-bit counter CNT runs 0..255, one per cycle.
  - Each cycle registers NCE=0, NWRT=0, {RA,CA}=CNT, DIN=0.
  - After issuing CNT=255, the next state is RUN. INIT_DONE rises on entry to RUN.
  - Both GNTs are 0 throughout INIT.
- RUN, grant:
  - PRI register, reset 0.
  - Only one REQ: grant it.
  - Both REQs: grant port PRI.
  - On any accept, PRI <= ~winner.
  - GNT depends only on REQ, PRI and state; there is no backpressure in RUN.
- Accept: the next cycle registers NCE=0, NWRT=~WE, {RA,CA}=ADDR, and DIN=WDATA for writes.
- No accept: NCE=1, NWRT=1. RA/CA/DIN hold their last value.
- Read return pipeline:
  - 2-stage tag shift {valid, port} for reads.
  - At stage 2, capture DO into Rx_RDATA and pulse Rx_RVALID for the tagged port.
  - Writes produce no response.
- Ordering: commands reach the SRAM in acceptance order.
  - Write then read to the same address in consecutive accepts returns the new data.
  - Read then write returns the old data.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - In-flight reads are discarded (no RVALID).
  - INIT restarts from CNT=0.

## Timing
- Reset values:
  - NCE=1, NWRT=1, RA=0, CA=0, DIN=0.
  - R0/R1_RVALID=0, R0/R1_RDATA=0.
  - INIT_DONE=0, PRI=0, CNT=0, tags invalid. GNTs=0 while in reset and INIT.
- Edge numbering: the accept edge is E0. The SRAM samples the registered command at E1, and DO is valid before E2 (SRAM clock-to-out 0.8 ns < tCLK 3 ns).
- Read latency: RDATA is captured at E2, and Rx_RVALID is high for the cycle following E2. That is 2 cycles from accept to RVALID.
- Throughput: one accept per cycle in RUN, and back-to-back reads from alternating ports are supported.
- INIT duration: 256 cycles. With CLEAR_ON_RESET=1 the first GNT is possible in the cycle after the first NRST-release edge plus 256 cycles.
- SRAM setup: every SRAM pin is a flop output, giving a full cycle minus clock-to-q against tAS=0.6 ns and tDS=tES=0.4 ns.

## Test plan
- Reset/INIT:
  - Stimulus: deassert NRST with REQs held high.
  - Required: NCE=0/NWRT=0 for exactly 256 cycles with addresses 0..255 and DIN=0; GNT=0 throughout; INIT_DONE=1 afterwards.
  - Required: a read of address 0xA7 returns 0.
- Single port write/read:
  - Stimulus: R0 writes 0x2ABCDEF to address 0x5C, then reads 0x5C in the next cycle.
  - Required: R0_RVALID exactly 2 cycles after the read accept, with R0_RDATA=0x2ABCDEF; R1_RVALID stays 0.
- Contention:
  - Stimulus: both REQs held high as reads for 6 cycles, at distinct preloaded addresses.
  - Required: grants alternate R0,R1,R0,R1,R0,R1; each port's RVALID carries its own address data in order.
- Hazard:
  - Stimulus: R1 writes 0x1111111 to address 0x03 while R0 reads 0x03 in the next cycle (PRI=1).
  - Required: R0 receives 0x1111111.
  - Stimulus (reverse order): read first, then write.
  - Required: the old value is returned.
- Reset mid-flight:
  - Stimulus: assert NRST one cycle after a read accept.
  - Required: no RVALID; all outputs at reset values immediately; INIT restarts at address 0.
- CLEAR_ON_RESET=0:
  - Required: INIT_DONE=1 and GNT available in the first cycle after reset release; the array is not written.
